// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART receiver and transmitter.
package uart_pkg;

  // Oversampling ratio: s_tick pulses per bit period.
  localparam int OVERSAMPLE = 16;
  // Tick index of the start-bit centre.
  localparam int MID_TICK = 7;

  // Receiver FSM encoding (plain constants so legacy tools can consume them).
  typedef logic [2:0] uart_state_t;
  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  // NOTE: non-blocking assignments make r_sync take the old r_meta, giving two real stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, LSB first, one done strobe per frame.
// Optional parity state compiled in with `define UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICK    = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 parity_err
);

  // Tick counter is 4 bits for start/data, widened when the stop phase needs more.
  localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] C_MID_TICK  = TW'(MID_TICK);
  localparam logic [TW-1:0] C_LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] C_STOP_TICK = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] C_LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  uart_state_t          r_state;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_done;
  logic                 r_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_perr;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  // Frame FSM: detects the start edge, samples each bit centre and publishes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_dout    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A falling edge is enough; s_tick is not needed to leave IDLE.
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_tick  <= '0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (r_tick == C_MID_TICK) begin
              if (!w_rx_s) begin
                r_state <= ST_DATA;
                r_tick  <= '0;
                r_bit   <= '0;
              end else begin
                // Line went high before the centre: a glitch, not a start bit.
                r_state <= ST_IDLE;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (r_tick == C_LAST_TICK) begin
              r_tick  <= '0;
              r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              if (r_bit == C_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (r_tick == C_LAST_TICK) begin
              r_tick    <= '0;
              r_par_bit <= w_rx_s;
              r_state   <= ST_STOP;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (s_tick) begin
            if (r_tick == C_STOP_TICK) begin
              // Frame is delivered even with a bad stop bit; the flag tells the consumer.
              r_dout  <= r_shift;
              r_ferr  <= ~w_rx_s;
              r_done  <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_perr  <= ((^r_shift) ^ r_par_bit) != PARITY_ODD;
`endif
              r_state <= ST_IDLE;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_dout      = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx with a queue-based scoreboard and monitor.
// Exercises the parity cases too when built with `define UART_RX_PARITY_EN.
module tb_uart_rx;

  // Scaled-down tick divider: same 16x oversampling, fewer clocks per tick.
  localparam int TICK_DIV = 8;
  localparam int BIT_CLKS = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       s_tick;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  exp_t    exp_q[$];
  int      n_tests;
  int      n_fail;
  int      n_done;
  int      n_pushed;
  longint  cyc;
  longint  done_cyc[$];
  logic    prev_done;

  uart_rx #(
    .DATA_BITS  (8),
    .SB_TICK    (16),
    .PARITY_ODD (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversample strobe: one clock wide every TICK_DIV clocks, free-running through reset.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d;
    e.ferr = fe;
    e.perr = pe;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic drive_bit(input logic b, input int ticks);
    rx = b;
    repeat (ticks * TICK_DIV) @(negedge clk);
  endtask

  // One frame LSB first; a bad stop is held low past the sample point, then released.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_ok);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, 16);
`else
    if (par) rx = 1'b1;
`endif
    if (stop_ok) begin
      drive_bit(1'b1, 16);
    end else begin
      drive_bit(1'b0, 10);
      drive_bit(1'b1, 6);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done strobe pops the next expected frame and compares it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rx_done_tick) begin
      n_done++;
      done_cyc.push_back(cyc);
      check("done_one_clk", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got rx_dout=%0h, expected no pulse", rx_dout);
      end else begin
        e = exp_q.pop_front();
        check("rx_dout", {24'd0, rx_dout}, {24'd0, e.data});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
      end
    end
    prev_done = rx_done_tick;
  end

  initial begin
    longint gap;
    int     done_before;
    n_tests   = 0;
    n_fail    = 0;
    n_done    = 0;
    n_pushed  = 0;
    cyc       = 0;
    prev_done = 1'b0;
    rx        = 1'b1;
    rst       = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_dout", {24'd0, rx_dout}, 32'd0);
    check("reset_done", {31'd0, rx_done_tick}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_perr", {31'd0, parity_err}, 32'd0);
    rst = 1'b0;
    drive_bit(1'b1, 32);

    // Single 8N1 frame.
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    drive_bit(1'b1, 16);

    // Back-to-back frames, no idle gap.
    done_before = done_cyc.size();
    expect_frame(8'hA3, 1'b0, 1'b0);
    expect_frame(8'h0F, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b1);
    drive_bit(1'b1, 16);
    check("b2b_pulses", done_cyc.size() - done_before, 32'd2);
    if (done_cyc.size() >= done_before + 2) begin
      gap = done_cyc[done_before + 1] - done_cyc[done_before];
      check("b2b_gap_ok",
            {31'd0, (gap >= FRAME_BITS * BIT_CLKS - TICK_DIV) && (gap <= FRAME_BITS * BIT_CLKS + TICK_DIV)},
            32'd1);
    end

    // Glitch: low for 4 ticks only, must not produce a frame.
    done_before = n_done;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check("glitch_no_done", n_done - done_before, 32'd0);
    check("glitch_dout_kept", {24'd0, rx_dout}, 32'h0F);

    // Bad stop bit, then a good frame clears the flag.
    expect_frame(8'hC4, 1'b1, 1'b0);
    send_frame(8'hC4, 1'b1, 1'b0);
    drive_bit(1'b1, 16);
    check("ferr_held", {31'd0, frame_err}, 32'd1);
    expect_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1);
    drive_bit(1'b1, 16);
    check("ferr_cleared", {31'd0, frame_err}, 32'd0);

    // Reset in the middle of data bit 3 of 0xFF.
    done_before = n_done;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16 * 3 + 8);
    rst = 1'b1;
    #1;
    check("midrst_dout", {24'd0, rx_dout}, 32'd0);
    check("midrst_done", {31'd0, rx_done_tick}, 32'd0);
    check("midrst_ferr", {31'd0, frame_err}, 32'd0);
    check("midrst_perr", {31'd0, parity_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1, 48);
    check("midrst_no_done", n_done - done_before, 32'd0);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    drive_bit(1'b1, 16);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so parity bit 1 is correct and 0 is wrong.
    expect_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1, 16);
    expect_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    drive_bit(1'b1, 16);
`endif

    drive_bit(1'b1, 32);
    check("all_frames_seen", exp_q.size(), 32'd0);
    check("done_count", n_done, n_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
